// File: rtl/re_demap.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : re_demap
//  Purpose  : Iterative ReMap decoder. Takes a code {k, m2}, inverts the
//             fraction remap (m2 -> m1), restores the hidden one and shifts
//             it to bit position k, one bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module re_demap #(
    parameter int NUM_LENGTH = 32,
    parameter int K_LENGTH   = 5,
    parameter int M2_LENGTH  = 27
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_LENGTH-1:0] code_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic [NUM_LENGTH-1:0] rslt_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i
);

    localparam int                  c_prod_w = 2 * M2_LENGTH;
    localparam int                  c_pad_w  = NUM_LENGTH - M2_LENGTH - 1;
    // Bit position the hidden one occupies straight after MAP
    localparam logic [K_LENGTH-1:0] c_point  = K_LENGTH'(M2_LENGTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAP   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [K_LENGTH-1:0]     k_q, k_d;
    logic [M2_LENGTH-1:0]    m2_q, m2_d;
    logic [NUM_LENGTH-1:0]   acc_q, acc_d;
    logic [K_LENGTH-1:0]     cnt_q, cnt_d;
    logic                    dir_q, dir_d;   // 1 = shift left, 0 = shift right
    logic                    live_q;         // low until the first clock after reset

    // Inverse fraction map: m1 = m2 - ((m2 * (2^M2 - m2)) >> (M2 + 2))
    logic [M2_LENGTH:0]      w_comp;
    logic [c_prod_w-1:0]     w_prod;
    logic [c_prod_w-1:0]     w_corr;
    logic [M2_LENGTH-1:0]    w_m1;
    logic                    w_unused_corr;

    assign w_comp        = {1'b1, {M2_LENGTH{1'b0}}} - {1'b0, m2_q};
    assign w_prod        = {{M2_LENGTH{1'b0}}, m2_q} * {{(M2_LENGTH-1){1'b0}}, w_comp};
    assign w_corr        = w_prod >> (M2_LENGTH + 2);
    // The correction never exceeds m2, so only the low M2 bits matter
    assign w_m1          = m2_q - w_corr[M2_LENGTH-1:0];
    assign w_unused_corr = ^w_corr[c_prod_w-1:M2_LENGTH];

    assign in_ready_o  = live_q && (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign rslt_o      = (state_q == DONE) ? acc_q : '0;

    // Next-state and datapath updates for the decode sequence
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m2_d    = m2_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i && in_ready_o) begin
                    k_d     = code_i[NUM_LENGTH-1:M2_LENGTH];
                    m2_d    = code_i[M2_LENGTH-1:0];
                    state_d = MAP;
                end
            end
            MAP: begin
                acc_d = {{c_pad_w{1'b0}}, 1'b1, w_m1};
                if (k_q < c_point) begin
                    dir_d = 1'b0;
                    cnt_d = c_point - k_q;
                end else if (k_q > c_point) begin
                    dir_d = 1'b1;
                    cnt_d = k_q - c_point;
                end else begin
                    dir_d = 1'b0;
                    cnt_d = '0;
                end
                state_d = (cnt_d == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                acc_d = dir_q ? (acc_q << 1) : (acc_q >> 1);
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == K_LENGTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            m2_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m2_q    <= m2_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            live_q  <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/re_demap.md
Name: re_demap

Overview:
- Inverse of the ReMap encoder: accepts a compressed code {k, m2} and reconstructs the 32-bit magnitude it represents.
- k is the leading-one position; m2 is the remapped Q0.27 fraction.
- Applies the inverse fraction map (m2 -> m1), restores the hidden one and shifts the result to bit position k.
- Multi-cycle, iterative, valid/ready on both sides; sits on the decode path after storage/transport of remapped values.

Parameters:
- NUM_LENGTH, 32, width of the reconstructed number and of the input code.
- K_LENGTH, 5, width of the exponent field k.
- M2_LENGTH, 27, width of the fraction field; NUM_LENGTH = K_LENGTH + M2_LENGTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- code_i  in  NUM_LENGTH  {k[31:27], m2[26:0]}.
- in_valid_i  in  1  code_i valid.
- in_ready_o  out  1  block can accept a code.
- rslt_o  out  NUM_LENGTH  reconstructed number.
- out_valid_o  out  1  rslt_o valid.
- out_ready_i  in  1  downstream accepts rslt_o.

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready_o=0 during reset, out_valid_o=0, rslt_o=0, all internal registers 0. After release, in_ready_o=1.
- Reset mid-operation aborts the transaction silently. No output is produced for it.
- FSM states: IDLE, MAP, SHIFT, DONE.
- in_ready_o=1 only in IDLE. out_valid_o=1 only in DONE.
- IDLE: on in_valid_i & in_ready_o, register k and m2, then go to MAP.
- MAP (one cycle):
  - m1 = m2 - ((m2 * (2^27 - m2)) >> 29), using a 54-bit product. m1 is never negative.
  - acc (32-bit) = zero-extended {1'b1, m1}.
  - If k<27: dir=right, cnt=27-k. If k>27: dir=left, cnt=k-27. If k=27: cnt=0.
  - Next state: DONE if cnt=0, else SHIFT.
- SHIFT:
  - Each cycle, acc shifts by 1 bit in direction dir, with zero fill; cnt decrements.
  - When the shift with cnt=1 completes, go to DONE.
  - Bits shifted out on the right are truncated, never rounded.
- DONE:
  - rslt_o=acc. rslt_o and out_valid_o are held stable while out_ready_i=0.
  - On out_ready_i=1, go to IDLE. in_ready_o rises the following cycle; there is no same-cycle pass-through.
- Latency from the accept edge to out_valid_o high: 2 cycles + |27-k| cycles.
  - Range: 2 (k=27) to 29 (k=0).
- Throughput: one transaction in flight.
- in_valid_i is ignored outside IDLE. code_i only needs to be valid at the accept edge.
- Boundaries:
  - k=0: result is always 1 (all fraction bits truncated).
  - Code 0x00000000 decodes to 1. Zero is not representable, and the encoder's zero input is decoded as 1.
  - k=31: the hidden one lands at bit 31; no overflow is possible.
  - m2=0: correction is 0, so m1=0.

Test Plan:
- Reset: assert rst_n=0 mid-SHIFT of k=0 code -> out_valid_o=0, rslt_o=0 immediately. After release, in_ready_o=1 and the next code decodes correctly.
- code k=27, m2=0x4000000 -> m1=0x3800000, rslt_o=0x0B800000, out_valid_o 2 cycles after accept.
- code k=28, m2=0x4000000 -> rslt_o=0x17000000 (left shift by 1), latency 3.
- code k=4, m2=0x4000000 -> rslt_o=0x00000017, latency 25.
- code k=31, m2=0 -> rslt_o=0x80000000, latency 6. Code 0x00000000 -> rslt_o=0x00000001, latency 29.
- Backpressure: hold out_ready_i=0 for 10 cycles in DONE while toggling in_valid_i with new codes -> rslt_o stable, in_ready_o=0, no codes accepted. Release -> exactly one output handshake, in_ready_o=1 the next cycle.
